cam_frame_capture_ctrl: RTL and testbench
=========================================

// Module: cam_frame_capture_ctrl
// PURPOSE
//  Frame-capture sequencer on the camera pixel-clock domain. Arms on a frame request and aligns
//  to camera VSYNC/HREF. Pairs the incoming bytes into MSB-first 16-bit pixels. Crops the full
//  sensor frame to a centred active window and writes each window pixel into the downstream FIFO.
//  Sits between the camera byte bus and the pixel FIFO feeding the UART path; start is gated by
//  the SCCB-setup-done flag.
// PARAMETERS
//  FrameWidth         640  sensor pixels per line (HREF-high pixels)
//  FrameHeight        480  sensor lines per frame
//  ActiveFrameWidth   512  cropped window width; XOFF = (FrameWidth-ActiveFrameWidth)/2 = 64
//  ActiveFrameHeight  384  cropped window height; YOFF = (FrameHeight-ActiveFrameHeight)/2 = 48
//  PixelBitWidth      16   output pixel width (two bytes)
// PORTS
//  p_clk         in   1   camera pixel clock; sole clock of the block
//  RST           in   1   synchronous, active-low reset (sampled on p_clk)
//  i_cfg_done    in   1   SCCB setup finished; already synchronised to p_clk
//  i_frame_req   in   1   1-cycle capture request; ignored unless IDLE and i_cfg_done=1
//  i_vsync       in   1   camera VSYNC, high during vertical blanking
//  i_href        in   1   camera HREF, high while line bytes are valid
//  i_data        in   8   camera byte bus
//  i_fifo_full   in   1   downstream FIFO full
//  o_fifo_wr     out  1   1-cycle FIFO write strobe
//  o_fifo_data   out  16  pixel {first byte, second byte}
//  o_busy        out  1   high in every state except IDLE
//  o_frame_done  out  1   1-cycle pulse at end of captured frame
//  o_overflow    out  1   sticky: at least one window pixel dropped this frame
// BEHAVIOUR
//  Reset (RST=0 at a p_clk edge): state=IDLE.
//   - All outputs 0; o_fifo_data=0.
//   - Byte phase, x/y counters and overflow cleared.
//   - Reset mid-frame aborts the capture immediately. No o_frame_done is produced.
//  FSM:
//   IDLE    -> ARM on i_frame_req && i_cfg_done; clear o_overflow on this transition.
//   ARM     -> SYNC when i_vsync=1. Discards any partial frame in progress.
//   SYNC    -> CAPTURE when i_vsync=0. Clear x, y and byte phase.
//   CAPTURE -> DONE on i_vsync=1, or when y reaches FrameHeight.
//   DONE    -> IDLE after one cycle; o_frame_done=1 during that cycle.
//  Byte pairing (CAPTURE only, i_href=1):
//   - Phase 0: latch i_data into the pixel MSB.
//   - Phase 1: latch the LSB and complete the pixel; phase toggles each HREF-high cycle.
//  Line accounting:
//   - HREF falling edge (registered i_href 1 -> 0): y+1, x=0, phase=0.
//   - A line holding an odd byte count drops its dangling byte.
//  Pixel position:
//   - x increments after each completed pixel.
//   - x saturates at FrameWidth; extra pixels are ignored.
//  Window test: XOFF <= x < XOFF+ActiveFrameWidth and YOFF <= y < YOFF+ActiveFrameHeight.
//  Write:
//   - A completed in-window pixel with i_fifo_full=0 gives o_fifo_wr=1 with o_fifo_data valid.
//   - Both are registered, one p_clk after the LSB byte was sampled.
//   - o_fifo_data holds its value between writes.
//  Overflow: an in-window pixel completing while i_fifo_full=1 is dropped (no strobe) and sets
//  o_overflow. Capture continues; o_overflow stays set until the next IDLE->ARM.
//  Counters: x, y are $clog2(FrameWidth+1) and $clog2(FrameHeight+1) bits, unsigned. No
//  wrap-around is possible.
//  i_frame_req outside IDLE is ignored and does not queue.
//  i_cfg_done dropping while busy has no effect on the current frame.
// CONFIGURATION
//  CAPTURE_TEST_PATTERN_EN defined:
//   - o_fifo_data = {y_win[7:0], x_win[7:0]}, where x_win = x-XOFF and y_win = y-YOFF.
//   - Timing, windowing and FIFO handshake are unchanged; i_data is ignored.
//  Not defined: o_fifo_data carries the camera bytes as specified above.
// TESTING
//  1. Reset with RST=0 for 3 cycles, then toggle HREF/VSYNC -> all outputs stay 0; o_busy=0.
//  2. cfg_done=1, frame_req pulse, full 640x480 frame of bytes 0xA5,0x3C -> 196608 writes.
//     - Each write carries 0xA53C.
//     - o_frame_done pulses exactly once; o_overflow=0.
//  3. Frame_req with cfg_done=0 -> stays IDLE, no writes; a second req during CAPTURE is ignored.
//  4. Hold fifo_full=1 for 10 in-window pixels on line 100 -> exactly 10 fewer writes (196598).
//     - o_overflow=1 until the next request.
//  5. Assert RST=0 at line 200 of CAPTURE -> next cycle IDLE, o_busy=0, no o_frame_done.
//     - A new request then captures a full frame.
//  6. With CAPTURE_TEST_PATTERN_EN: first write = 0x0000, last = 0x7FFF.
//     - Line 1 starts with 0x0100; write count 196608.

Source files
------------

// File: rtl/cam_frame_capture_ctrl_if.sv
// Camera byte bus plus pixel-FIFO write port of the frame-capture sequencer.
// slave is the sequencer's view; master is the camera/FIFO environment's view.
interface cam_frame_capture_ctrl_if #(
   parameter int unsigned PixelBitWidth = 16
);
   logic                     i_cfg_done;
   logic                     i_frame_req;
   logic                     i_vsync;
   logic                     i_href;
   logic [7:0]               i_data;
   logic                     i_fifo_full;
   logic                     o_fifo_wr;
   logic [PixelBitWidth-1:0] o_fifo_data;
   logic                     o_busy;
   logic                     o_frame_done;
   logic                     o_overflow;

   modport master (
      output i_cfg_done, i_frame_req, i_vsync, i_href, i_data, i_fifo_full,
      input  o_fifo_wr, o_fifo_data, o_busy, o_frame_done, o_overflow
   );

   modport slave (
      input  i_cfg_done, i_frame_req, i_vsync, i_href, i_data, i_fifo_full,
      output o_fifo_wr, o_fifo_data, o_busy, o_frame_done, o_overflow
   );
endinterface

// File: rtl/cam_frame_capture_ctrl.sv
// Camera frame-capture sequencer: pairs VSYNC/HREF-framed bytes into 16-bit pixels and writes a
// centred crop to the pixel FIFO. Define CAPTURE_TEST_PATTERN_EN to emit {y_win, x_win} instead.
module cam_frame_capture_ctrl #(
   parameter int unsigned FrameWidth        = 640,
   parameter int unsigned FrameHeight       = 480,
   parameter int unsigned ActiveFrameWidth  = 512,
   parameter int unsigned ActiveFrameHeight = 384,
   parameter int unsigned PixelBitWidth     = 16
) (
   input logic                     p_clk,
   input logic                     RST,
   cam_frame_capture_ctrl_if.slave bus
);

   localparam int unsigned XW = $clog2(FrameWidth + 1);
   localparam int unsigned YW = $clog2(FrameHeight + 1);
   localparam int unsigned XOff = (FrameWidth - ActiveFrameWidth) / 2;
   localparam int unsigned YOff = (FrameHeight - ActiveFrameHeight) / 2;
   localparam logic [XW-1:0] XLo  = XW'(XOff);
   localparam logic [XW-1:0] XHi  = XW'(XOff + ActiveFrameWidth);
   localparam logic [XW-1:0] XMax = XW'(FrameWidth);
   localparam logic [YW-1:0] YLo  = YW'(YOff);
   localparam logic [YW-1:0] YHi  = YW'(YOff + ActiveFrameHeight);
   localparam logic [YW-1:0] YMax = YW'(FrameHeight);

   typedef enum logic [2:0] {StIdle, StArm, StSync, StCapture, StDone} state_e;

   state_e                   state_q, state_d;
   logic                     phase_q, phase_d;
   logic                     href_q;
   logic [7:0]               msb_q, msb_d;
   logic [XW-1:0]            x_q, x_d;
   logic [YW-1:0]            y_q, y_d;
   logic                     wr_q, wr_d;
   logic [PixelBitWidth-1:0] data_q, data_d;
   logic                     ovf_q, ovf_d;
   logic                     in_win;
   logic [15:0]              pix;

   assign in_win = (x_q >= XLo) && (x_q < XHi) && (y_q >= YLo) && (y_q < YHi);

`ifdef CAPTURE_TEST_PATTERN_EN
   logic [XW-1:0] x_win;
   logic [YW-1:0] y_win;
   logic          unused_msb;
   assign x_win      = x_q - XLo;
   assign y_win      = y_q - YLo;
   assign pix        = {8'(y_win), 8'(x_win)};
   assign unused_msb = ^msb_q;
`else
   assign pix = {msb_q, bus.i_data};
`endif

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      msb_d   = msb_q;
      x_d     = x_q;
      y_d     = y_q;
      wr_d    = 1'b0;
      data_d  = data_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (bus.i_frame_req && bus.i_cfg_done) begin
               state_d = StArm;
               ovf_d   = 1'b0;
            end
         end
         StArm: begin
            if (bus.i_vsync) state_d = StSync;
         end
         StSync: begin
            if (!bus.i_vsync) begin
               state_d = StCapture;
               x_d     = '0;
               y_d     = '0;
               phase_d = 1'b0;
            end
         end
         StCapture: begin
            if (bus.i_vsync || (y_q == YMax)) state_d = StDone;
            if (bus.i_href) begin
               phase_d = ~phase_q;
               if (!phase_q) begin
                  msb_d = bus.i_data;
               end else if (x_q != XMax) begin
                  // Pixels beyond the sensor width are ignored so x never wraps.
                  x_d = x_q + 1'b1;
                  if (in_win) begin
                     if (bus.i_fifo_full) begin
                        ovf_d = 1'b1;
                     end else begin
                        wr_d   = 1'b1;
                        data_d = PixelBitWidth'(pix);
                     end
                  end
               end
            end else if (href_q && (y_q != YMax)) begin
               // End of line: any dangling odd byte is dropped by resetting the phase.
               y_d     = y_q + 1'b1;
               x_d     = '0;
               phase_d = 1'b0;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge p_clk) begin
      if (!RST) begin
         state_q <= StIdle;
         phase_q <= 1'b0;
         href_q  <= 1'b0;
         msb_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         wr_q    <= 1'b0;
         data_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         href_q  <= bus.i_href;
         msb_q   <= msb_d;
         x_q     <= x_d;
         y_q     <= y_d;
         wr_q    <= wr_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.o_fifo_wr    = wr_q;
   assign bus.o_fifo_data  = data_q;
   assign bus.o_busy       = (state_q != StIdle);
   assign bus.o_frame_done = (state_q == StDone);
   assign bus.o_overflow   = ovf_q;

endmodule

// File: tb/tb_cam_frame_capture_ctrl.sv
// Scoreboard bench for cam_frame_capture_ctrl on a scaled 16x12 sensor with an 8x6 window.
// Honours CAPTURE_TEST_PATTERN_EN in its expected-pixel model.
module tb_cam_frame_capture_ctrl;

   localparam int unsigned Fw   = 16;
   localparam int unsigned Fh   = 12;
   localparam int unsigned Aw   = 8;
   localparam int unsigned Ah   = 6;
   localparam int unsigned XOff = (Fw - Aw) / 2;
   localparam int unsigned YOff = (Fh - Ah) / 2;

   logic p_clk = 1'b0;
   logic RST   = 1'b0;

   cam_frame_capture_ctrl_if #(.PixelBitWidth(16)) bus ();

   cam_frame_capture_ctrl #(
      .FrameWidth       (Fw),
      .FrameHeight      (Fh),
      .ActiveFrameWidth (Aw),
      .ActiveFrameHeight(Ah),
      .PixelBitWidth    (16)
   ) dut (
      .p_clk(p_clk),
      .RST  (RST),
      .bus  (bus)
   );

   always #5 p_clk = ~p_clk;

   int          checks    = 0;
   int          failures  = 0;
   int          wr_cnt    = 0;
   int          done_cnt  = 0;
   logic [15:0] exp_q[$];
   logic [15:0] last_pix  = '0;
   bit          have_last = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Output monitor: pops the scoreboard on each write, checks hold between writes.
   always @(negedge p_clk) begin
      if (bus.o_busy !== 1'b1) have_last = 1'b0;
      if (bus.o_fifo_wr === 1'b1) begin
         wr_cnt++;
         if (exp_q.size() != 0) begin
            last_pix  = exp_q.pop_front();
            have_last = 1'b1;
            check_eq("pix", 32'(bus.o_fifo_data), 32'(last_pix));
         end
      end else if (have_last) begin
         check_eq("hold", 32'(bus.o_fifo_data), 32'(last_pix));
      end
      if (bus.o_frame_done === 1'b1) done_cnt++;
   end

   task automatic pulse_req();
      bus.i_frame_req = 1'b1;
      @(negedge p_clk);
      bus.i_frame_req = 1'b0;
   endtask

   // Line 4 carries 40 pixels (x saturation), line 5 an extra odd byte.
   task automatic run_frame(input int n_lines, input int full_line, input int rst_line,
                            input bit req_mid);
      bus.i_vsync = 1'b1;
      repeat (3) @(negedge p_clk);
      bus.i_vsync = 1'b0;
      repeat (3) @(negedge p_clk);
      for (int y = 0; y < n_lines; y++) begin
         int npix;
         if (y == rst_line) begin
            RST = 1'b0;
            @(negedge p_clk);
            RST = 1'b1;
            return;
         end
         npix = (y == 4) ? 40 : Fw;
         for (int x = 0; x < npix; x++) begin
            logic [7:0]  b0, b1;
            logic [15:0] exp_pix;
            bit          in_win, full;
            b0     = 8'(x * 7 + y * 13);
            b1     = 8'(x ^ (y << 4) ^ 8'h5A);
            in_win = (x >= XOff) && (x < XOff + Aw) && (y >= YOff) && (y < YOff + Ah);
            full   = (y == full_line) && (x >= XOff + 2) && (x < XOff + 5);
`ifdef CAPTURE_TEST_PATTERN_EN
            exp_pix = {8'(y - YOff), 8'(x - XOff)};
`else
            exp_pix = {b0, b1};
`endif
            bus.i_frame_req = req_mid && (y == 1) && (x == 0);
            bus.i_href      = 1'b1;
            bus.i_data      = b0;
            @(negedge p_clk);
            bus.i_frame_req = 1'b0;
            bus.i_data      = b1;
            bus.i_fifo_full = full;
            if (in_win && !full) exp_q.push_back(exp_pix);
            @(negedge p_clk);
            bus.i_fifo_full = 1'b0;
         end
         if (y == 5) begin
            bus.i_data = 8'hEE;
            @(negedge p_clk);
         end
         bus.i_href = 1'b0;
         repeat (4) @(negedge p_clk);
      end
      if (n_lines < Fh) begin
         bus.i_vsync = 1'b1;
         repeat (3) @(negedge p_clk);
         bus.i_vsync = 1'b0;
      end
   endtask

   task automatic frame_checks(input string tag, input int wr0, input int done0,
                               input int exp_wr, input int exp_done, input logic exp_ovf);
      for (int i = 0; i < 16 && bus.o_busy; i++) @(negedge p_clk);
      check_eq({tag, "_busy"}, 32'(bus.o_busy), 0);
      check_eq({tag, "_writes"}, wr_cnt - wr0, exp_wr);
      check_eq({tag, "_done"}, done_cnt - done0, exp_done);
      check_eq({tag, "_ovf"}, 32'(bus.o_overflow), 32'(exp_ovf));
      check_eq({tag, "_pending"}, exp_q.size(), 0);
   endtask

   initial begin
      int wr0, done0;
      bus.i_cfg_done  = 1'b0;
      bus.i_frame_req = 1'b0;
      bus.i_vsync     = 1'b0;
      bus.i_href      = 1'b0;
      bus.i_data      = 8'h00;
      bus.i_fifo_full = 1'b0;

      // Reset held for 3 cycles while HREF/VSYNC toggle.
      for (int i = 0; i < 3; i++) begin
         @(negedge p_clk);
         bus.i_href  = ~bus.i_href;
         bus.i_vsync = ~bus.i_vsync;
         check_eq("rst_busy", 32'(bus.o_busy), 0);
         check_eq("rst_wr", 32'(bus.o_fifo_wr), 0);
         check_eq("rst_done", 32'(bus.o_frame_done), 0);
         check_eq("rst_ovf", 32'(bus.o_overflow), 0);
         check_eq("rst_data", 32'(bus.o_fifo_data), 0);
      end
      RST = 1'b1;

      // Request without cfg_done is ignored.
      wr0 = wr_cnt;
      pulse_req();
      for (int i = 0; i < 4; i++) begin
         bus.i_href  = ~bus.i_href;
         bus.i_vsync = ~bus.i_vsync;
         @(negedge p_clk);
      end
      bus.i_href  = 1'b0;
      bus.i_vsync = 1'b0;
      @(negedge p_clk);
      check_eq("nocfg_busy", 32'(bus.o_busy), 0);
      check_eq("nocfg_writes", wr_cnt - wr0, 0);

      // Full frame with a stray request mid-capture.
      bus.i_cfg_done = 1'b1;
      wr0 = wr_cnt; done0 = done_cnt;
      pulse_req();
      check_eq("arm_busy", 32'(bus.o_busy), 1);
      run_frame(Fh, -1, -1, 1'b1);
      frame_checks("full", wr0, done0, Aw * Ah, 1, 1'b0);
      repeat (10) @(negedge p_clk);
      check_eq("noqueue_busy", 32'(bus.o_busy), 0);

      // Three in-window pixels dropped on line 4.
      wr0 = wr_cnt; done0 = done_cnt;
      pulse_req();
      run_frame(Fh, 4, -1, 1'b0);
      frame_checks("ovf", wr0, done0, Aw * Ah - 3, 1, 1'b1);
      repeat (5) @(negedge p_clk);
      check_eq("ovf_sticky", 32'(bus.o_overflow), 1);

      // Frame ended by VSYNC after 8 lines; the request clears overflow.
      wr0 = wr_cnt; done0 = done_cnt;
      pulse_req();
      check_eq("ovf_cleared", 32'(bus.o_overflow), 0);
      run_frame(8, -1, -1, 1'b0);
      frame_checks("vsync", wr0, done0, (8 - YOff) * Aw, 1, 1'b0);

      // Reset at the start of line 7 aborts the capture.
      wr0 = wr_cnt; done0 = done_cnt;
      pulse_req();
      run_frame(Fh, -1, 7, 1'b0);
      check_eq("abort_busy_now", 32'(bus.o_busy), 0);
      frame_checks("abort", wr0, done0, (7 - YOff) * Aw, 0, 1'b0);

      // Fresh capture after the abort; cfg_done drops while busy.
      wr0 = wr_cnt; done0 = done_cnt;
      pulse_req();
      bus.i_cfg_done = 1'b0;
      run_frame(Fh, -1, -1, 1'b0);
      frame_checks("after", wr0, done0, Aw * Ah, 1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
